// File: rtl/fact_initiator.sv
// fact_initiator
//   Bus initiator that runs one factorial job on the factorial peripheral's
//   2-bit-address register interface. A job writes n, sets go, polls done,
//   reads the 32-bit result and then clears go. The controlling logic sees a
//   start/busy/done/err handshake.
//
//   Peripheral address map: 0 = n (4 bits), 1 = go (bit 0),
//                           2 = done (bit 0), 3 = result (32 bits).
//
//   Parameters:
//     TIMEOUT  maximum number of POLL cycles before the job aborts with err
//     TO_W     width of the poll counter (TIMEOUT < 2**TO_W)
//
//   Optional build macro:
//     FACT_RANGE_CHECK_EN  reject n > 12 (result would overflow 32 bits):
//                          err is set, busy pulses for one cycle, no bus access.
//
//   Ports:
//     clk     in   system clock, rising edge
//     rst     in   synchronous active-high reset
//     start   in   job request, sampled only in IDLE
//     n       in   factorial operand, captured on an accepted start
//     busy    out  high while a job is in progress
//     done    out  one-cycle pulse, result valid
//     err     out  sticky timeout/range flag, cleared by the next accepted start
//     result  out  last factorial read from the peripheral
//     A       out  peripheral address (registered)
//     WE      out  peripheral write enable (registered)
//     WD      out  peripheral write data (registered)
//     RD      in   peripheral read data, combinational from A
module fact_initiator #(
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned TO_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  n,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] result,
   output logic [1:0]  A,
   output logic        WE,
   output logic [3:0]  WD,
   input  logic [31:0] RD
);

   typedef enum logic [2:0] {
      IDLE,
      WR_N,
      WR_GO,
      POLL,
      RD_RES,
      CLR_GO,
      ABORT,
      RANGE_ERR
   } state_t;

   localparam logic [1:0]      ADDR_N    = 2'd0;
   localparam logic [1:0]      ADDR_GO   = 2'd1;
   localparam logic [1:0]      ADDR_DONE = 2'd2;
   localparam logic [1:0]      ADDR_RES  = 2'd3;
   localparam logic [TO_W-1:0] LAST_POLL = TO_W'(TIMEOUT - 1);

   state_t          state;
   logic [TO_W-1:0] pollCnt;
   logic            outOfRange;

`ifdef FACT_RANGE_CHECK_EN
   assign outOfRange = (n > 4'd12);
`else
   assign outOfRange = 1'b0;
`endif

   // Bus outputs are loaded on the edge that enters a state, so every state
   // presents its own A/WE/WD for the whole cycle it is active. The n write
   // data is loaded straight into WD on the accepting edge; WD itself is the
   // operand latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         result  <= '0;
         A       <= ADDR_N;
         WE      <= 1'b0;
         WD      <= '0;
         pollCnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (outOfRange) begin
                     err   <= 1'b1;
                     state <= RANGE_ERR;
                  end else begin
                     err   <= 1'b0;
                     A     <= ADDR_N;
                     WE    <= 1'b1;
                     WD    <= n;
                     state <= WR_N;
                  end
               end
            end
            WR_N: begin
               A     <= ADDR_GO;
               WE    <= 1'b1;
               WD    <= 4'b0001;
               state <= WR_GO;
            end
            WR_GO: begin
               A       <= ADDR_DONE;
               WE      <= 1'b0;
               WD      <= '0;
               pollCnt <= '0;
               state   <= POLL;
            end
            POLL: begin
               if (RD[0]) begin
                  A     <= ADDR_RES;
                  state <= RD_RES;
               end else if (pollCnt == LAST_POLL) begin
                  A     <= ADDR_GO;
                  WE    <= 1'b1;
                  WD    <= '0;
                  state <= ABORT;
               end else begin
                  pollCnt <= pollCnt + 1'b1;
               end
            end
            RD_RES: begin
               result <= RD;
               A      <= ADDR_GO;
               WE     <= 1'b1;
               WD     <= '0;
               done   <= 1'b1;   // pulse lines up with the CLR_GO cycle
               state  <= CLR_GO;
            end
            CLR_GO: begin
               A     <= ADDR_N;
               WE    <= 1'b0;
               WD    <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            ABORT: begin
               err   <= 1'b1;
               A     <= ADDR_N;
               WE    <= 1'b0;
               WD    <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            RANGE_ERR: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               A     <= ADDR_N;
               WE    <= 1'b0;
               WD    <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fact_initiator.sv
// tb_fact_initiator
//   Directed-plus-random bench for fact_initiator. A behavioural peripheral
//   (n/go/done/result registers with a programmable done delay) sits on the
//   bus; expected results come from a factorial table, and expected bus
//   traces and cycle counts from the job rules.
module tb_fact_initiator;

   localparam int unsigned TMO = 20;

   // n! mod 2**32 for n = 0..15
   localparam logic [31:0] FACT [16] = '{
      32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040,
      32'd40320, 32'd362880, 32'd3628800, 32'd39916800, 32'd479001600,
      32'd1932053504, 32'd1278945280, 32'd2004310016 };

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  n;
   logic        busy, done, err;
   logic [31:0] result;
   logic [1:0]  A;
   logic        WE;
   logic [3:0]  WD;
   logic [31:0] RD;

   fact_initiator #(.TIMEOUT(TMO), .TO_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .n(n),
      .busy(busy), .done(done), .err(err), .result(result),
      .A(A), .WE(WE), .WD(WD), .RD(RD)
   );

   always #5 clk = ~clk;

   // ---------------- peripheral model ----------------
   logic [3:0]  pN;
   logic        pGo;
   logic [15:0] pCnt;
   int unsigned pDelay = 0;
   bit          pNever = 1'b0;
   logic        pDone;

   function automatic logic [31:0] periphFact(input logic [3:0] k);
      logic [31:0] f;
      f = 32'd1;
      for (int unsigned i = 2; i <= k; i++) f = f * 32'(i);
      return f;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pN <= '0; pGo <= 1'b0; pCnt <= '0;
      end else if (WE) begin
         if (A == 2'd0) pN <= WD;
         if (A == 2'd1) begin pGo <= WD[0]; pCnt <= '0; end
      end else if (pGo && pCnt != 16'hFFFF) begin
         pCnt <= pCnt + 16'd1;
      end
   end

   assign pDone = pGo && !pNever && (32'(pCnt) >= pDelay);

   // upper bits of the done register carry junk the initiator must ignore
   always_comb begin
      case (A)
         2'd0:    RD = {28'd0, pN};
         2'd1:    RD = {31'd0, pGo};
         2'd2:    RD = {31'h2AAA5555, pDone};
         default: RD = periphFact(pN);
      endcase
   end

   // ---------------- bus/handshake monitor ----------------
   logic [5:0]  wrLog [$];
   logic [31:0] doneRes [$];
   int unsigned doneCyc [$];
   int unsigned cyc = 0, busyCnt = 0, pollCnt = 0, readCnt = 0, doneCnt = 0, wideCnt = 0;
   bit          prevDone = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (WE) wrLog.push_back({A, WD});
      if (busy) busyCnt++;
      if (A == 2'd2 && !WE) pollCnt++;
      if (A == 2'd3 && !WE) readCnt++;
      if (done) begin
         doneCnt++;
         doneRes.push_back(result);
         doneCyc.push_back(cyc);
         if (prevDone) wideCnt++;
      end
      prevDone = done;
   end

   // ---------------- checking ----------------
   int unsigned compCnt = 0;
   int unsigned failCnt = 0;
   logic [31:0] expResult = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic checkWrites(input string tag, input int unsigned w0, input logic [5:0] expW [$]);
      check({tag, " wr count"}, wrLog.size() - w0, expW.size());
      if (wrLog.size() - w0 == expW.size())
         foreach (expW[i]) check({tag, " wr entry"}, 32'(wrLog[w0 + i]), 32'(expW[i]));
   endtask

   task automatic runJob(input string tag, input logic [3:0] nIn,
                         input int unsigned dly, input bit never);
      int unsigned w0, b0, p0, r0, d0, wd0, k;
      bit          rangeErr;
      logic [5:0]  expW [$];
      rangeErr = 1'b0;
`ifdef FACT_RANGE_CHECK_EN
      rangeErr = (nIn > 4'd12);
`endif
      pDelay = dly; pNever = never;
      w0 = wrLog.size(); b0 = busyCnt; p0 = pollCnt; r0 = readCnt;
      d0 = doneCnt; wd0 = wideCnt;
      n = nIn; start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " busy after accept"}, busy, 1'b1);
      check({tag, " err after accept"}, err, rangeErr);
      k = 0;
      while (busy && k < 300) begin step(); k++; end
      check({tag, " job finished in bound"}, busy, 1'b0);
      if (rangeErr) begin
         checkWrites(tag, w0, expW);
         check({tag, " busy cycles"}, busyCnt - b0, 1);
         check({tag, " done count"}, doneCnt - d0, 0);
         check({tag, " err"}, err, 1'b1);
      end else begin
         expW.push_back({2'd0, nIn});
         expW.push_back({2'd1, 4'd1});
         expW.push_back({2'd1, 4'd0});
         checkWrites(tag, w0, expW);
         if (never) begin
            check({tag, " polls"}, pollCnt - p0, TMO);
            check({tag, " reads"}, readCnt - r0, 0);
            check({tag, " done count"}, doneCnt - d0, 0);
            check({tag, " busy cycles"}, busyCnt - b0, TMO + 3);
            check({tag, " err"}, err, 1'b1);
         end else begin
            expResult = FACT[nIn];
            check({tag, " polls"}, pollCnt - p0, dly + 1);
            check({tag, " reads"}, readCnt - r0, 1);
            check({tag, " done count"}, doneCnt - d0, 1);
            check({tag, " done width"}, wideCnt - wd0, 0);
            check({tag, " busy cycles"}, busyCnt - b0, dly + 5);
            if (doneCnt - d0 == 1) check({tag, " result at done"}, doneRes[d0], FACT[nIn]);
            check({tag, " err"}, err, 1'b0);
         end
      end
      check({tag, " result held"}, result, expResult);
      check({tag, " WE idle"}, WE, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int unsigned w0, d0, p0, k;
      logic [3:0]  rn;
      rst = 1'b1; start = 1'b0; n = '0;
      step(); step();
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset err", err, 1'b0);
      check("reset result", result, 32'd0);
      check("reset A", A, 2'd0);
      check("reset WE", WE, 1'b0);
      check("reset WD", WD, 4'd0);
      // start together with rst: rst wins
      start = 1'b1; n = 4'd5;
      step();
      start = 1'b0;
      check("rst beats start busy", busy, 1'b0);
      check("rst beats start WE", WE, 1'b0);
      rst = 1'b0;
      step();

      runJob("n5", 4'd5, 8, 1'b0);
      runJob("n0", 4'd0, 0, 1'b0);

      // back-to-back with start held high
      pDelay = 2; pNever = 1'b0;
      w0 = wrLog.size(); d0 = doneCnt;
      n = 4'd12; start = 1'b1;
      step();
      n = 4'd3;
      k = 0;
      while (doneCnt < d0 + 2 && k < 300) begin step(); k++; end
      start = 1'b0;
      k = 0;
      while (busy && k < 300) begin step(); k++; end
      check("b2b done count", doneCnt - d0, 2);
      if (doneCnt - d0 >= 2) begin
         check("b2b first result", doneRes[d0], 32'd479001600);
         check("b2b second result", doneRes[d0 + 1], 32'd6);
         check("b2b done spacing", doneCyc[d0 + 1] - doneCyc[d0], 8);
      end
      check("b2b writes", wrLog.size() - w0, 6);
      check("b2b final result", result, 32'd6);
      expResult = 32'd6;

      // start toggled during POLL must not queue a second job
      pDelay = 6;
      w0 = wrLog.size(); d0 = doneCnt;
      n = 4'd4; start = 1'b1;
      k = 0;
      do begin
         step(); k++;
         start = (A == 2'd2) ? ~start : 1'b0;
      end while (busy && k < 300);
      start = 1'b0;
      repeat (3) step();
      check("toggle done count", doneCnt - d0, 1);
      check("toggle writes", wrLog.size() - w0, 3);
      check("toggle result", result, 32'd24);
      expResult = 32'd24;

      for (int i = 0; i < 5; i++) begin
         rn = 4'($urandom_range(0, 12));
         runJob("random", rn, $urandom_range(0, 10), 1'b0);
      end

      runJob("timeout", 4'd6, 0, 1'b1);
      runJob("err clear", 4'd3, 1, 1'b0);
      runJob("timeout2", 4'd9, 0, 1'b1);

      // reset in the 3rd POLL cycle
      pDelay = 15; pNever = 1'b0;
      w0 = wrLog.size(); p0 = pollCnt;
      n = 4'd7; start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (pollCnt - p0 < 3 && k < 50) begin step(); k++; end
      check("reached 3rd poll", pollCnt - p0, 3);
      rst = 1'b1;
      step();
      check("mid rst WE", WE, 1'b0);
      check("mid rst A", A, 2'd0);
      check("mid rst busy", busy, 1'b0);
      check("mid rst done", done, 1'b0);
      check("mid rst err", err, 1'b0);
      check("mid rst result", result, 32'd0);
      check("mid rst no go clear", wrLog.size() - w0, 2);
      rst = 1'b0;
      expResult = '0;
      step();

      runJob("n13", 4'd13, 3, 1'b0);
      runJob("after n13", 4'd10, 4, 1'b0);

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
      $finish;
   end

endmodule
